// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared types and constants for the stack controller
// Holds the FSM state encoding, the default setup/pulse timings and the
// data/counter widths used by stack_ctrl and stack_ctrl_timer.
package stack_ctrl_pkg;

  localparam int DATA_W        = 4;
  localparam int CNT_W         = 3;
  localparam int SETUP_CYC_DEF = 1;
  localparam int PULSE_CYC_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PUSH_HI,
    PUSH_HOLD,
    POP_HI,
    POP_CAP,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/stack_ctrl_timer.sv
// rtl/stack_ctrl_timer.sv - loadable down-counter timing setup and strobe phases
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   load         reload the counter with load_val (takes priority)
//   load_val     value to load; a phase lasts load_val+1 cycles
//   zero         counter has reached 0 (it stops there, no wrap)
module stack_ctrl_timer
  import stack_ctrl_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - CPU-side controller sequencing push/pop/flush on a strobed stack
// Ports:
//   Clk, Reset                    clock, asynchronous active-high reset
//   req_push, req_pop, req_flush  command requests, sampled only in IDLE
//   wdata                         push data, captured when a push is accepted
//   rdata                         last popped value
//   done, cmd_err                 completion pulse; cmd_err flags a refused command
//   busy                          command in progress (after accept through done)
//   DataIO                        bidirectional stack data bus
//   Push, Pop                     registered stack strobes
//   StackReset                    Reset or flush strobe
//   Full, Empty                   stack status, decide refusal in IDLE
//   Err, SP                       stack status for observation only
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_push,
  input  logic              req_pop,
  input  logic              req_flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              cmd_err,
  output logic              busy,
  inout  logic [DATA_W-1:0] DataIO,
  output logic              Push,
  output logic              Pop,
  output logic              StackReset,
  input  logic              Full,
  input  logic              Empty,
  input  logic              Err,
  input  logic [2:0]        SP
);

  // A phase of N cycles is a load of N-1 followed by counting to zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);

  state_t            state, next_state;
  logic              refuse;
  logic              err_q;
  logic              push_q, pop_q, drive_q, flush_q;
  logic [DATA_W-1:0] data_q;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic              timer_zero;

  // Err and SP are not needed by the sequencing; they are only observed.
  logic unused_status;
  assign unused_status = Err ^ (^SP);

  stack_ctrl_timer u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    next_state = state;
    refuse     = 1'b0;
    case (state)
      IDLE: begin
        if (req_flush) begin
          next_state = FLUSH;
        end else if (req_push && req_pop) begin
          next_state = DONE;
          refuse     = 1'b1;
        end else if (req_push) begin
          next_state = Full ? DONE : SETUP;
          refuse     = Full;
        end else if (req_pop) begin
          next_state = Empty ? DONE : POP_HI;
          refuse     = Empty;
        end
      end
      SETUP:     if (timer_zero) next_state = PUSH_HI;
      PUSH_HI:   if (timer_zero) next_state = PUSH_HOLD;
      PUSH_HOLD: next_state = DONE;
      POP_HI:    if (timer_zero) next_state = POP_CAP;
      POP_CAP:   next_state = DONE;
      FLUSH:     next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase

    // Reload on every state entry so each phase starts from a full count.
    timer_load = (next_state != state);
    timer_val  = '0;
    if (next_state == SETUP) begin
      timer_val = SETUP_LD;
    end else if (next_state == PUSH_HI || next_state == POP_HI) begin
      timer_val = PULSE_LD;
    end
  end

  // Strobes and bus enable are registered from next_state so they are
  // glitch-free yet still track the state exactly; async reset drops them at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      drive_q <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      rdata   <= '0;
    end else begin
      state   <= next_state;
      push_q  <= (next_state == PUSH_HI);
      pop_q   <= (next_state == POP_HI);
      drive_q <= (next_state == SETUP) || (next_state == PUSH_HI) ||
                 (next_state == PUSH_HOLD);
      flush_q <= (next_state == FLUSH);
      if (state == IDLE) begin
        err_q <= refuse;
      end
      if (state == IDLE && next_state == SETUP) begin
        data_q <= wdata;
      end
      // Capture on the final Pop-high edge, while the stack still drives the bus.
      if (state == POP_HI && timer_zero) begin
        rdata <= DataIO;
      end
    end
  end

  assign DataIO     = drive_q ? data_q : {DATA_W{1'bz}};
  assign Push       = push_q;
  assign Pop        = pop_q;
  assign StackReset = Reset | flush_q;
  assign done       = (state == DONE);
  assign cmd_err    = (state == DONE) && err_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl with a behavioural 7-deep stack
module tb_stack_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       req_push = 1'b0, req_pop = 1'b0, req_flush = 1'b0;
  logic [3:0] wdata = 4'h0;
  logic [3:0] rdata;
  logic       done, cmd_err, busy, Push, Pop, StackReset;
  logic       Full, Empty, Err;
  logic [2:0] SP;
  wire  [3:0] dataio;

  // Behavioural stack: stores on Push rise, drives top while Pop, shrinks on Pop fall.
  logic [3:0] mem [0:7];
  logic [2:0] sp = 3'd0;
  logic       push_d = 1'b0, pop_d = 1'b0;

  pullup pu0 (dataio[0]);
  pullup pu1 (dataio[1]);
  pullup pu2 (dataio[2]);
  pullup pu3 (dataio[3]);

  assign dataio = Pop ? mem[sp - 3'd1] : 4'bzzzz;
  assign Full   = (sp == 3'd7);
  assign Empty  = (sp == 3'd0);
  assign Err    = 1'b0;
  assign SP     = sp;

  always @(negedge Clk) begin
    if (StackReset) begin
      sp <= 3'd0;
    end else begin
      if (Push && !push_d) begin
        mem[sp] <= dataio;
        sp      <= sp + 3'd1;
      end
      if (!Pop && pop_d) sp <= sp - 3'd1;
    end
    push_d <= Push;
    pop_d  <= Pop;
  end

  stack_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_push   (req_push),
    .req_pop    (req_pop),
    .req_flush  (req_flush),
    .wdata      (wdata),
    .rdata      (rdata),
    .done       (done),
    .cmd_err    (cmd_err),
    .busy       (busy),
    .DataIO     (dataio),
    .Push       (Push),
    .Pop        (Pop),
    .StackReset (StackReset),
    .Full       (Full),
    .Empty      (Empty),
    .Err        (Err),
    .SP         (SP)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // Issue one command, follow it to done (bounded), then step back to IDLE.
  task automatic run_cmd(input string tag, input bit p, input bit q, input bit f,
                         input logic [3:0] d, input int exp_lat, input int exp_err,
                         input int exp_push, input int exp_pop, input int exp_sr,
                         input bit noise);
    int lat = 0;
    int err = 0;
    int npush = 0;
    int npop = 0;
    int nsr = 0;
    req_push = p; req_pop = q; req_flush = f; wdata = d;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      tick();
      req_push  = 1'b0;
      req_flush = 1'b0;
      req_pop   = noise && (n == 2 || n == 3);
      npush += int'(Push);
      npop  += int'(Pop);
      nsr   += int'(StackReset);
      if (done) begin
        lat = n;
        err = int'(cmd_err);
      end
    end
    req_pop = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_cmd_err"}, err, exp_err);
    check({tag, "_push_cycles"}, npush, exp_push);
    check({tag, "_pop_cycles"}, npop, exp_pop);
    check({tag, "_stackreset_cycles"}, nsr, exp_sr);
    tick();
  endtask

  localparam int LAT_PUSH = 5;
  localparam int LAT_POP  = 4;
  localparam int LAT_FL   = 2;
  localparam int LAT_REF  = 1;

  logic [3:0] exp_dio  [5] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hF};
  logic       exp_push [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       exp_done [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int cnt_a;
    int cnt_b;
    repeat (3) tick();
    check("rst_push", int'(Push), 0);
    check("rst_pop", int'(Pop), 0);
    check("rst_done", int'(done), 0);
    check("rst_cmd_err", int'(cmd_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rdata", int'(rdata), 0);
    check("rst_stackreset", int'(StackReset), 1);
    check("rst_dataio_z", int'(dataio), 15);

    Reset = 1'b0;
    tick();
    check("idle_stackreset", int'(StackReset), 0);

    // Push A, cycle by cycle.
    req_push = 1'b1; wdata = 4'hA;
    for (int c = 1; c <= 5; c++) begin
      tick();
      req_push = 1'b0;
      check($sformatf("pushA_c%0d_dataio", c), int'(dataio), int'(exp_dio[c-1]));
      check($sformatf("pushA_c%0d_push", c), int'(Push), int'(exp_push[c-1]));
      check($sformatf("pushA_c%0d_done", c), int'(done), int'(exp_done[c-1]));
      check($sformatf("pushA_c%0d_busy", c), int'(busy), 1);
    end
    tick();
    check("pushA_sp", int'(SP), 1);
    check("pushA_empty", int'(Empty), 0);
    check("pushA_busy_after", int'(busy), 0);

    run_cmd("flush1", 0, 0, 1, 4'h0, LAT_FL, 0, 0, 0, 1, 0);
    check("flush1_sp", int'(SP), 0);

    run_cmd("push3", 1, 0, 0, 4'h3, LAT_PUSH, 0, 2, 0, 0, 0);
    run_cmd("push5", 1, 0, 0, 4'h5, LAT_PUSH, 0, 2, 0, 0, 0);
    run_cmd("pop1", 0, 1, 0, 4'h0, LAT_POP, 0, 0, 2, 0, 0);
    check("pop1_rdata", int'(rdata), 5);
    run_cmd("pop2", 0, 1, 0, 4'h0, LAT_POP, 0, 0, 2, 0, 0);
    check("pop2_rdata", int'(rdata), 3);
    check("pop2_sp", int'(SP), 0);

    for (int i = 1; i <= 7; i++) begin
      run_cmd($sformatf("fill%0d", i), 1, 0, 0, 4'(i), LAT_PUSH, 0, 2, 0, 0, 0);
    end
    check("fill_sp", int'(SP), 7);
    check("fill_full", int'(Full), 1);
    run_cmd("push_full", 1, 0, 0, 4'hF, LAT_REF, 1, 0, 0, 0, 0);
    check("push_full_sp", int'(SP), 7);

    run_cmd("flush2", 0, 0, 1, 4'h0, LAT_FL, 0, 0, 0, 1, 0);
    check("flush2_empty", int'(Empty), 1);
    run_cmd("pop_empty", 0, 1, 0, 4'h0, LAT_REF, 1, 0, 0, 0, 0);
    check("pop_empty_rdata", int'(rdata), 3);

    run_cmd("push_and_pop", 1, 1, 0, 4'h7, LAT_REF, 1, 0, 0, 0, 0);
    check("push_and_pop_sp", int'(SP), 0);

    // Pop requested while busy must be dropped, not queued.
    run_cmd("busy_ignore", 1, 0, 0, 4'h9, LAT_PUSH, 0, 2, 0, 0, 1);
    cnt_a = 0; cnt_b = 0;
    repeat (4) begin
      tick();
      cnt_a += int'(Pop);
      cnt_b += int'(busy);
    end
    check("busy_ignore_pop", cnt_a, 0);
    check("busy_ignore_busy", cnt_b, 0);
    check("busy_ignore_sp", int'(SP), 1);

    // Reset asserted during PUSH_HI.
    req_push = 1'b1; wdata = 4'h6;
    tick();
    req_push = 1'b0;
    tick();
    check("rstmid_push_before", int'(Push), 1);
    check("rstmid_dataio_before", int'(dataio), 6);
    Reset = 1'b1;
    #1;
    check("rstmid_push", int'(Push), 0);
    check("rstmid_dataio_z", int'(dataio), 15);
    check("rstmid_busy", int'(busy), 0);
    repeat (2) tick();
    Reset = 1'b0;
    cnt_a = 0; cnt_b = 0;
    repeat (5) begin
      tick();
      cnt_a += int'(done);
      cnt_b += int'(busy);
    end
    check("rstmid_no_done", cnt_a, 0);
    check("rstmid_idle", cnt_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
